mdu_iter: RTL and testbench

Iterative multiply/divide unit for the MIPS EX stage. It sits beside the combinational ALU and owns the HI/LO register pair. It executes MULT/MULTU/DIV/DIVU with a 32-cycle radix-2 datapath, and MTHI/MTLO in one cycle. The pipeline stalls on `busy` and flushes in-flight work on interrupt/exception via `cancel`.

---
 rtl/mdu_iter_pkg.sv | 42 ++++
 rtl/mdu_iter_if.sv | 36 +++
 rtl/mdu_iter_negate.sv | 25 ++
 rtl/mdu_iter.sv | 223 ++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared encodings for the iterative multiply/divide unit.
// Holds the MDU opcode constants (they sit next to the ALU opcodes in the
// pipeline decode), the controller state encoding, and the divide-by-zero
// LO constant. Small decode helpers keep the op classification in one place.
package mdu_iter_pkg;

  localparam int MDU_W = 32;

  // MDU opcodes; 3'd6 and 3'd7 are reserved and act as no-ops.
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  // LO value produced by any division whose divisor is zero.
  localparam logic [MDU_W-1:0] DIV0_LO = 32'hFFFF_FFFF;

  // True for the four iterative ops (MULT/MULTU/DIV/DIVU).
  function automatic logic op_is_md(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // True for the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  // True for the divide variants.
  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: EX-stage <-> MDU connection.
// master (pipeline) drives start/op/a/b/cancel; slave (mdu_iter) returns
// busy/done and the architectural HI/LO registers.
//   start  - request, sampled only while the unit is idle
//   op     - MDU opcode (see mdu_iter_pkg)
//   a, b   - rs / rt operands
//   cancel - exception flush of in-flight work
//   busy   - stall request, high while iterating
//   done   - one-cycle pulse when HI/LO take a mult/div result
//   hi, lo - HI/LO registers
interface mdu_iter_if #(
  parameter int WIDTH = 32
) ();
  import mdu_iter_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_iter_negate.sv
// mdu_negate: conditional two's-complement of a W-bit word (combinational).
//   i_en  - 1: output -i_val, 0: output i_val unchanged
//   i_val - input word
//   o_val - result (modulo 2^W, so the most negative value maps to itself)
module mdu_negate
  import mdu_iter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         i_en,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  // Select between the word and its two's complement.
  always_comb begin
    o_val = i_val;
    if (i_en) begin
      o_val = ~i_val + {{(W-1){1'b0}}, 1'b1};
    end else begin
      o_val = i_val;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit owning the HI/LO pair.
// MULT/MULTU/DIV/DIVU run on operand magnitudes, one bit per cycle for ITER
// cycles, followed by a one-cycle FINISH in which done pulses. MTHI/MTLO
// write HI/LO directly from IDLE. cancel aborts CALC/FINISH at the next edge.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mdu_iter_if.slave (start/op/a/b/cancel in, busy/done/hi/lo out)
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = MDU_W,
  parameter int ITER  = MDU_W
) (
  input  logic         clk,
  input  logic         rst,
  mdu_iter_if.slave    bus
);

  localparam int            CW       = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [CW-1:0]    r_cnt;
  // r_hw/r_lw: product high/low (mult) or remainder/dividend-quotient (div).
  logic [WIDTH-1:0] r_hw;
  logic [WIDTH-1:0] r_lw;
  logic [WIDTH-1:0] r_m;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_a_raw;   // dividend as given, for divide-by-zero HI
  logic             r_is_div;
  logic             r_neg_q;   // result (product/quotient) must be negated
  logic             r_neg_r;   // remainder must be negated
  logic             r_div0;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic               w_a_neg_en;
  logic               w_b_neg_en;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [WIDTH-1:0]   w_step_hw;
  logic [WIDTH-1:0]   w_step_lw;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  assign w_a_neg_en = op_is_signed(bus.op) & bus.a[WIDTH-1];
  assign w_b_neg_en = op_is_signed(bus.op) & bus.b[WIDTH-1];

  mdu_negate #(.W(WIDTH)) u_neg_a (
    .i_en(w_a_neg_en), .i_val(bus.a), .o_val(w_a_mag)
  );

  mdu_negate #(.W(WIDTH)) u_neg_b (
    .i_en(w_b_neg_en), .i_val(bus.b), .o_val(w_b_mag)
  );

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    w_mul_sum   = {1'b0, r_hw} + (r_lw[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    w_div_shift = {r_hw, r_lw[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_m};
    w_step_hw   = r_hw;
    w_step_lw   = r_lw;
    if (r_is_div) begin
      // No borrow means the shifted remainder covers the divisor.
      if (!w_div_diff[WIDTH]) begin
        w_step_hw = w_div_diff[WIDTH-1:0];
        w_step_lw = {r_lw[WIDTH-2:0], 1'b1};
      end else begin
        w_step_hw = w_div_shift[WIDTH-1:0];
        w_step_lw = {r_lw[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Add into the high half, then shift the 65-bit {carry,hi,lo} right.
      w_step_hw = w_mul_sum[WIDTH:1];
      w_step_lw = {w_mul_sum[0], r_lw[WIDTH-1:1]};
    end
  end

  // Sign fix-up operates on the final iteration's output so HI/LO can be
  // written on the same edge the last bit is produced.
  mdu_negate #(.W(2*WIDTH)) u_neg_prod (
    .i_en(r_neg_q), .i_val({w_step_hw, w_step_lw}), .o_val(w_prod_fix)
  );

  mdu_negate #(.W(WIDTH)) u_neg_quo (
    .i_en(r_neg_q), .i_val(w_step_lw), .o_val(w_quo_fix)
  );

  mdu_negate #(.W(WIDTH)) u_neg_rem (
    .i_en(r_neg_r), .i_val(w_step_hw), .o_val(w_rem_fix)
  );

  // Select the HI/LO values written at the end of CALC.
  always_comb begin
    w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_fix[WIDTH-1:0];
    if (!r_is_div) begin
      w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod_fix[WIDTH-1:0];
    end else if (r_div0) begin
      w_res_hi = r_a_raw;
      w_res_lo = WIDTH'(DIV0_LO);
    end else begin
      w_res_hi = w_rem_fix;
      w_res_lo = w_quo_fix;
    end
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; cancel overrides everything outside IDLE and
  // suppresses start inside IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!bus.cancel && bus.start && op_is_md(bus.op)) begin
          w_next_state = S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.cancel) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = S_FINISH;
        end else begin
          w_next_state = S_CALC;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Datapath, HI/LO and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= {CW{1'b0}};
      r_hw     <= {WIDTH{1'b0}};
      r_lw     <= {WIDTH{1'b0}};
      r_m      <= {WIDTH{1'b0}};
      r_a_raw  <= {WIDTH{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
    end else begin
      r_busy <= (w_next_state == S_CALC);
      r_done <= (w_next_state == S_FINISH);
      case (r_state)
        S_IDLE: begin
          if (!bus.cancel && bus.start) begin
            case (bus.op)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                r_cnt    <= {CW{1'b0}};
                r_hw     <= {WIDTH{1'b0}};
                // Divide shifts the dividend out of lw; multiply consumes
                // multiplier bits from lw.
                r_lw     <= op_is_div(bus.op) ? w_a_mag : w_b_mag;
                r_m      <= op_is_div(bus.op) ? w_b_mag : w_a_mag;
                r_a_raw  <= bus.a;
                r_is_div <= op_is_div(bus.op);
                r_neg_q  <= op_is_signed(bus.op) &
                            (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_neg_r  <= op_is_signed(bus.op) & bus.a[WIDTH-1];
                r_div0   <= (bus.b == {WIDTH{1'b0}});
              end
              MDU_MTHI: r_hi <= bus.a;
              MDU_MTLO: r_lo <= bus.a;
              default: begin
                r_cnt <= r_cnt;
              end
            endcase
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_CALC: begin
          r_hw  <= w_step_hw;
          r_lw  <= w_step_lw;
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          // Only a completed, uncancelled op reaches FINISH.
          if (w_next_state == S_FINISH) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end else begin
            r_hi <= r_hi;
          end
        end
        S_FINISH: r_cnt <= {CW{1'b0}};
        default:  r_cnt <= {CW{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed test of mdu_iter against a cycle-level behavioural
// model that derives results from plain 64-bit arithmetic, plus literal
// expectations for each scenario.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Behavioural model state.
  logic        m_busy;
  logic        m_done;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  int          m_left;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {hi,lo} result of a mult/div from the architectural definition.
  function automatic logic [63:0] md_result(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Cycle-level model: 32 busy cycles, then a one-cycle done with the result.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= 32'h0;
      m_lo   <= 32'h0;
      m_pend <= 64'h0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (bus.cancel) begin
          m_busy <= 1'b0;
        end else if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
        end else begin
          m_left <= m_left - 1;
        end
      end else if (m_done) begin
        m_left <= 0;
      end else if (!bus.cancel && bus.start) begin
        if (bus.op <= 3'd3) begin
          m_busy <= 1'b1;
          m_left <= 32;
          m_pend <= md_result(bus.op, bus.a, bus.b);
        end else if (bus.op == 3'd4) begin
          m_hi <= bus.a;
        end else if (bus.op == 3'd5) begin
          m_lo <= bus.a;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_busy", 64'(bus.busy), 64'(m_busy));
      chk("cyc_done", 64'(bus.done), 64'(m_done));
      chk("cyc_hi",   64'(bus.hi),   64'(m_hi));
      chk("cyc_lo",   64'(bus.lo),   64'(m_lo));
    end
  end

  // Present a request for one edge; returns at posedge+2.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
  endtask

  // Wait for done with a cycle budget; lat = edges seen, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #2;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Full mult/div transaction with literal result and latency checks.
  task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    issue(op, a, b);
    chk({name, "_busy"}, 64'(bus.busy), 64'(1));
    wait_done(lat);
    chk({name, "_lat"}, 64'(lat), 64'(32));
    chk({name, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({name, "_lo"}, 64'(bus.lo), 64'(elo));
    @(posedge clk);
    #2;
    chk({name, "_done_off"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    int lat;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.a      = 32'h0;
    bus.b      = 32'h0;
    bus.cancel = 1'b0;

    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_hi",   64'(bus.hi),   64'(0));
    chk("rst_lo",   64'(bus.lo),   64'(0));
    check_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;

    // Multiply, signed and unsigned.
    run_md("mult",  MDU_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);

    // Divide, signed and unsigned.
    run_md("div",  MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);

    // Divide by zero and the signed overflow case.
    run_md("div0",  MDU_DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_md("divov", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Back-to-back MTHI / MTLO.
    bus.start = 1'b1;
    bus.op    = MDU_MTHI;
    bus.a     = 32'hDEAD_BEEF;
    @(posedge clk);
    #2;
    chk("mthi_hi", 64'(bus.hi), 64'(32'hDEAD_BEEF));
    chk("mthi_busy", 64'(bus.busy), 64'(0));
    bus.op = MDU_MTLO;
    bus.a  = 32'h0BAD_F00D;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    chk("mtlo_lo", 64'(bus.lo), 64'(32'h0BAD_F00D));
    chk("mtlo_hi", 64'(bus.hi), 64'(32'hDEAD_BEEF));
    chk("mtlo_done", 64'(bus.done), 64'(0));

    // Cancel mid-CALC discards the result.
    issue(MDU_MTHI, 32'h1111_1111, 32'h0);
    issue(MDU_MTLO, 32'h1111_1111, 32'h0);
    issue(MDU_MULT, 32'd5, 32'd5);
    repeat (10) @(posedge clk);
    #2;
    bus.cancel = 1'b1;
    @(posedge clk);
    #2;
    bus.cancel = 1'b0;
    chk("cancel_busy", 64'(bus.busy), 64'(0));
    chk("cancel_done", 64'(bus.done), 64'(0));
    chk("cancel_hi", 64'(bus.hi), 64'(32'h1111_1111));
    chk("cancel_lo", 64'(bus.lo), 64'(32'h1111_1111));
    run_md("post_cancel", MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

    // Asynchronous reset mid-divide.
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_hi",   64'(bus.hi),   64'(0));
    chk("midrst_lo",   64'(bus.lo),   64'(0));
    @(posedge clk);
    #2 rst = 1'b0;

    // start while busy is ignored.
    issue(MDU_MULT, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    #2;
    issue(MDU_MULTU, 32'd100, 32'd100);
    wait_done(lat);
    chk("ignore_lat", 64'(lat), 64'(26));
    chk("ignore_hi", 64'(bus.hi), 64'(0));
    chk("ignore_lo", 64'(bus.lo), 64'(63));
    @(posedge clk);
    #2;

    // cancel together with start in IDLE suppresses the write.
    bus.cancel = 1'b1;
    issue(MDU_MTHI, 32'h5555_5555, 32'h0);
    bus.cancel = 1'b0;
    chk("idle_cancel_hi", 64'(bus.hi), 64'(0));

    // Reserved opcode is a no-op.
    issue(3'd6, 32'hABCD_0000, 32'd1);
    chk("rsvd_busy", 64'(bus.busy), 64'(0));
    chk("rsvd_lo", 64'(bus.lo), 64'(63));
    @(posedge clk);
    #2;

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
